// File: rtl/keypad_pkg.sv
// Shared constants, key map and FSM state type for the keypad scanner.
package keypad_pkg;

  localparam logic [3:0] NO_KEY   = 4'd10;
  localparam logic [3:0] KEY_STAR = 4'd11;
  localparam logic [3:0] KEY_HASH = 4'd12;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DIGIT,
    PRESS_FN,
    LOCKOUT
  } keypad_state_t;

  // Rows 0..2 carry digits 1..9 left to right; row 3 is '*', 0, '#'.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    if (r == 2'd3) begin
      case (c)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = {2'b00, r} * 4'd3 + {2'b00, c} + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_debouncer.sv
// Accepts a scan code once it has been seen on DEBOUNCE_SCANS consecutive full scans.
module keypad_debouncer
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scan_done,
  input  logic [3:0] raw_code,
  output logic       accept,
  output logic [3:0] accepted_code
);

  localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

  logic [3:0] prev_code_reg;
  logic [3:0] count_reg;
  logic [3:0] count_next;
  logic       accept_reg;
  logic [3:0] accepted_code_reg;
  logic       fire;

  always_comb begin
    count_next = count_reg;
    fire       = 1'b0;
    if (scan_done) begin
      if (raw_code == prev_code_reg) begin
        if (count_reg < DEB) count_next = count_reg + 4'd1;
      end else begin
        count_next = 4'd1;
      end
      // Fire only on the first scan that reaches the threshold for this code.
      fire = (count_next == DEB) && ((count_reg != DEB) || (raw_code != prev_code_reg));
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_code_reg     <= NO_KEY;
      count_reg         <= 4'd0;
      accept_reg        <= 1'b0;
      accepted_code_reg <= NO_KEY;
    end else begin
      accept_reg <= fire;
      if (scan_done) begin
        prev_code_reg <= raw_code;
        count_reg     <= count_next;
      end
      if (fire) accepted_code_reg <= raw_code;
    end
  end

  assign accept        = accept_reg;
  assign accepted_code = accepted_code_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: column drive, row sync, scan decode and press FSM.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES    = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       time_button,
  output logic       alarm_button
);

  localparam logic [7:0] LAST_CYC = 8'(SCAN_CYCLES - 1);

  logic [3:0]  row_meta_reg, row_sync_reg;
  logic [7:0]  cyc_reg, cyc_next;
  logic [1:0]  col_idx_reg, col_idx_next;
  logic [2:0]  col_reg, col_next;
  logic [11:0] press_reg, press_next;
  logic        sample, scan_done;
  logic [3:0]  raw_code, hits;
  logic        accept;
  logic [3:0]  accepted_code;

  keypad_state_t state_reg, state_next;
  logic [3:0]    key_reg, key_next;
  logic          key_valid_reg, key_valid_next;
  logic          time_button_reg, time_button_next;
  logic          alarm_button_reg, alarm_button_next;

  assign sample    = (cyc_reg == LAST_CYC);
  assign scan_done = sample && (col_idx_reg == 2'd2);

  always_comb begin
    cyc_next     = cyc_reg + 8'd1;
    col_idx_next = col_idx_reg;
    if (sample) begin
      cyc_next     = 8'd0;
      col_idx_next = (col_idx_reg == 2'd2) ? 2'd0 : col_idx_reg + 2'd1;
    end
    col_next = ~(3'b001 << col_idx_next);
  end

  // Rows read low are pressed; the current column's bits are replaced on its last cycle.
  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    for (genvar gj = 0; gj < 3; gj++) begin : g_col
      assign press_next[gi*3+gj] = (sample && (col_idx_reg == 2'(gj))) ?
                                   ~row_sync_reg[gi] : press_reg[gi*3+gj];
    end
  end

  always_comb begin
    hits     = 4'd0;
    raw_code = NO_KEY;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (press_next[r*3+c]) begin
          hits     = hits + 4'd1;
          raw_code = key_code(2'(r), 2'(c));
        end
      end
    end
    // Two or more closed switches may be a ghost; report nothing.
    if (hits != 4'd1) raw_code = NO_KEY;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      row_meta_reg <= 4'hF;
      row_sync_reg <= 4'hF;
      cyc_reg      <= 8'd0;
      col_idx_reg  <= 2'd0;
      col_reg      <= 3'b110;
      press_reg    <= 12'd0;
    end else begin
      row_meta_reg <= row;
      row_sync_reg <= row_meta_reg;
      cyc_reg      <= cyc_next;
      col_idx_reg  <= col_idx_next;
      col_reg      <= col_next;
      press_reg    <= press_next;
    end
  end

  keypad_debouncer #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debouncer (
    .clock        (clock),
    .reset        (reset),
    .scan_done    (scan_done),
    .raw_code     (raw_code),
    .accept       (accept),
    .accepted_code(accepted_code)
  );

  always_comb begin
    state_next        = state_reg;
    key_next          = key_reg;
    key_valid_next    = 1'b0;
    time_button_next  = 1'b0;
    alarm_button_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (accepted_code <= 4'd9) begin
            state_next     = PRESS_DIGIT;
            key_next       = accepted_code;
            key_valid_next = 1'b1;
          end else if (accepted_code == KEY_STAR) begin
            state_next       = PRESS_FN;
            time_button_next = 1'b1;
          end else if (accepted_code == KEY_HASH) begin
            state_next        = PRESS_FN;
            alarm_button_next = 1'b1;
          end
        end
      end
      PRESS_DIGIT: begin
        if (accept) begin
          key_next   = NO_KEY;
          state_next = (accepted_code == NO_KEY) ? IDLE : LOCKOUT;
        end
      end
      PRESS_FN: begin
        if (accept) state_next = (accepted_code == NO_KEY) ? IDLE : LOCKOUT;
      end
      default: begin
        key_next = NO_KEY;
        if (accept && (accepted_code == NO_KEY)) state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg        <= IDLE;
      key_reg          <= NO_KEY;
      key_valid_reg    <= 1'b0;
      time_button_reg  <= 1'b0;
      alarm_button_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      key_reg          <= key_next;
      key_valid_reg    <= key_valid_next;
      time_button_reg  <= time_button_next;
      alarm_button_reg <= alarm_button_next;
    end
  end

  assign col          = col_reg;
  assign key          = key_reg;
  assign key_valid    = key_valid_reg;
  assign time_button  = time_button_reg;
  assign alarm_button = alarm_button_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x3 switch matrix.
module tb_keypad_scanner;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row;
  logic [2:0] col;
  logic [3:0] key;
  logic       key_valid, time_button, alarm_button;
  logic [11:0] mask = 12'd0;

  int checks = 0;
  int failures = 0;
  int kv_cnt = 0, tb_cnt = 0, ab_cnt = 0, excl_viol = 0;
  int kv0, tb0, ab0;

  localparam int K1 = 0, K3 = 2, K5 = 4, K6 = 5, K7 = 6, K9 = 8, KSTAR = 9, K0 = 10, KHASH = 11;

  keypad_scanner dut (
    .clock       (clock),
    .reset       (reset),
    .row         (row),
    .col         (col),
    .key         (key),
    .key_valid   (key_valid),
    .time_button (time_button),
    .alarm_button(alarm_button)
  );

  always #5 clock = ~clock;

  // A closed switch pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (mask[r*3+c] && !col[c]) row[r] = 1'b0;
  end

  always @(negedge clock) begin
    kv_cnt += int'(key_valid);
    tb_cnt += int'(time_button);
    ab_cnt += int'(alarm_button);
    if (int'(key_valid) + int'(time_button) + int'(alarm_button) > 1) excl_viol++;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic hold(input int k);
    mask = 12'd0;
    mask[k] = 1'b1;
  endtask

  task automatic wait_key(input string tag, input int exp, input int budget);
    int n = 0;
    while (int'(key) != exp && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(tag, int'(key), exp);
  endtask

  task automatic snap();
    kv0 = kv_cnt; tb0 = tb_cnt; ab0 = ab_cnt;
  endtask

  initial begin
    // 1: reset and column rotation
    run(5);
    check("rst_col", int'(col), 3'b110);
    check("rst_key", int'(key), 10);
    check("rst_pulses", kv_cnt + tb_cnt + ab_cnt, 0);
    reset = 1'b1;
    run(1);
    check("rot_c0", int'(col), 3'b110);
    run(3);
    check("rot_c1", int'(col), 3'b101);
    run(4);
    check("rot_c2", int'(col), 3'b011);
    run(4);
    check("rot_wrap", int'(col), 3'b110);
    run(40);

    // 2: clean press of '5'
    snap();
    hold(K5);
    wait_key("k5_press", 5, 50);
    run(40);
    check("k5_valid_once", kv_cnt - kv0, 1);
    mask = 12'd0;
    wait_key("k5_release", 10, 50);
    run(10);

    // 3: bounce on '0', aligned to the start of the middle column window
    begin
      int n = 0;
      while (col == 3'b101 && n < 16) begin @(negedge clock); n++; end
      while (col != 3'b101 && n < 32) begin @(negedge clock); n++; end
    end
    snap();
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) hold(K0); else mask = 12'd0;
      run(5);
    end
    check("bounce_no_valid", kv_cnt - kv0, 0);
    check("bounce_key_idle", int'(key), 10);
    hold(K0);
    run(80);
    check("k0_key", int'(key), 0);
    check("k0_valid_once", kv_cnt - kv0, 1);
    mask = 12'd0;
    wait_key("k0_release", 10, 50);
    run(10);

    // 4: function keys
    snap();
    hold(KSTAR);
    run(80);
    check("star_pulse", tb_cnt - tb0, 1);
    check("star_key_idle", int'(key), 10);
    mask = 12'd0;
    run(60);
    hold(KHASH);
    run(80);
    check("hash_pulse", ab_cnt - ab0, 1);
    check("hash_no_time", tb_cnt - tb0, 1);
    mask = 12'd0;
    run(60);
    check("fn_no_valid", kv_cnt - kv0, 0);

    // 5a: two keys at once are rejected
    snap();
    mask = 12'd0;
    mask[K1] = 1'b1;
    mask[K9] = 1'b1;
    run(80);
    check("ghost_key", int'(key), 10);
    check("ghost_pulses", (kv_cnt - kv0) + (tb_cnt - tb0) + (ab_cnt - ab0), 0);
    mask = 12'd0;
    run(60);

    // 5b: slide from '3' to '6' without releasing
    snap();
    hold(K3);
    wait_key("k3_press", 3, 50);
    hold(K6);
    wait_key("slide_lockout", 10, 50);
    run(40);
    check("slide_no_valid", kv_cnt - kv0, 1);
    mask = 12'd0;
    run(60);
    hold(K6);
    wait_key("k6_press", 6, 50);
    run(10);
    check("k6_valid", kv_cnt - kv0, 2);
    mask = 12'd0;
    wait_key("k6_release", 10, 50);
    run(10);

    // 6: reset while '7' is held
    hold(K7);
    wait_key("k7_press", 7, 50);
    run(5);
    reset = 1'b0;
    run(1);
    reset = 1'b1;
    check("midrst_key", int'(key), 10);
    check("midrst_col", int'(col), 3'b110);
    snap();
    wait_key("k7_reaccept", 7, 50);
    run(20);
    check("k7_valid_once", kv_cnt - kv0, 1);
    mask = 12'd0;
    wait_key("k7_release", 10, 50);

    check("pulse_exclusive", excl_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Front end for the alarm clock's keypad path. Scans a physical 4-row x 3-column matrix keypad, debounces presses and encodes them into the key protocol that alarm_clock_top consumes.
- Key protocol: key = 0..9 while a digit is held, key = 10 when idle.
- Separate one-cycle pulses are generated for time_button ('*') and alarm_button ('#').
- Sits between the board pins and alarm_clock_top in the top-level design.

Parameters:
- SCAN_CYCLES, 4, clock cycles each column is driven low.
- DEBOUNCE_SCANS, 3, number of consecutive identical full-scan results required to accept a new state (range 1..15).

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low reset.
- row  input  4  keypad rows; active-low, externally pulled up; asynchronous to clock.
- col  output  3  column drives; active-low, exactly one bit low at a time.
- key  output  4  debounced digit 0..9; 10 means no key.
- key_valid  output  1  one-cycle pulse when key takes a new digit value.
- time_button  output  1  one-cycle pulse on accepted '*'.
- alarm_button  output  1  one-cycle pulse on accepted '#'.

Behaviour:
- Reset (reset==0 at a clock edge) produces the following on the next cycle:
  - col=3'b110, key=10, key_valid=0, time_button=0, alarm_button=0.
  - FSM=IDLE, all counters 0, row synchroniser 4'hF, previous scan code 10.
- Synchronisation: row passes through a 2-flop synchroniser before any use.
- Column sequencing:
  - col_idx cycles 0,1,2,0..., holding each value SCAN_CYCLES cycles; col = ~(3'b001 << col_idx).
  - A full scan takes 3*SCAN_CYCLES cycles (12 at default).
- Sampling: synchronised rows are sampled on the last cycle of each column window, giving 12 press bits per scan.
- Key map (row r, column c):
  - r0: 1,2,3
  - r1: 4,5,6
  - r2: 7,8,9
  - r3: '*',0,'#'
- Raw scan code at end of each scan:
  - exactly one bit pressed -> that key's code (digits 0..9, '*'=11, '#'=12).
  - zero bits pressed -> 10.
  - two or more bits pressed -> 10 (ghost rejection).
- Debounce:
  - If raw code equals the previous raw code, the stable count increments, saturating at DEBOUNCE_SCANS; otherwise the count is set to 1.
  - An accept event fires in the cycle the count first reaches DEBOUNCE_SCANS.
  - With DEBOUNCE_SCANS=1, every code change is accepted at the end of its scan.
- FSM (acts only on accept events with accepted code A):
  - IDLE:
    - A=digit d -> PRESS_DIGIT; key=d; key_valid pulses.
    - A=11 -> PRESS_FN; time_button pulses.
    - A=12 -> PRESS_FN; alarm_button pulses.
    - A=10 -> stay in IDLE.
  - PRESS_DIGIT:
    - key holds d for the whole press.
    - A=10 -> IDLE; key=10.
    - Any other A -> LOCKOUT; key=10, no pulse.
  - PRESS_FN:
    - A=10 -> IDLE.
    - Any other A -> LOCKOUT.
  - LOCKOUT:
    - key=10; no pulses.
    - A=10 -> IDLE.
- Rule: a new press is recognised only after a debounced release.
- Timing:
  - All outputs are registered.
  - Pulses are high for exactly one cycle, starting the cycle after the accept event.
  - key changes in that same cycle.
  - Worst-case press-to-key latency at defaults is 2 + 12*(DEBOUNCE_SCANS+1) = 50 cycles.
- Boundaries:
  - Bounce shorter than one full stable debounce window never produces an accept.
  - Reset mid-press forces key=10 and IDLE. If the key is still held after reset releases, it is re-accepted with one key_valid.
  - At most one of key_valid, time_button and alarm_button is high in any cycle.

Decomposition:
- Package keypad_pkg holds:
  - constants NO_KEY=10, KEY_STAR=11, KEY_HASH=12.
  - the key-map function (row,col)->code.
  - the FSM state enum (IDLE, PRESS_DIGIT, PRESS_FN, LOCKOUT).
- Sub-module keypad_debouncer: takes the raw scan code plus a scan_done strobe and emits accept/accepted_code. Column sequencing, synchroniser and FSM stay in keypad_scanner.

Test Plan:
1. Hold reset low 5 cycles, rows=4'hF -> col=110, key=10, all pulses 0 throughout; col rotates 110,101,011 every 4 cycles after release.
2. Model key '5' (row1 low while col[1] low), held 80 cycles, then released:
   - key=5 within 50 cycles of press.
   - exactly one key_valid.
   - key=10 within 50 cycles of release.
3. Bounce key '0' (toggle every 5 cycles for 40 cycles), then hold 80 cycles -> no key_valid during bounce; one key_valid with key=0 afterwards.
4. Press '*' for 80 cycles -> one time_button pulse, key stays 10; then press '#' -> one alarm_button pulse; key_valid never asserts.
5. Ghosting and lockout:
   - Hold '1' and '9' together -> key stays 10, no pulses.
   - Hold '3' until accepted, then slide to '6' without release -> key returns to 10, no second key_valid until release, then press '6' -> key=6 with one key_valid.
6. With '7' accepted, assert reset 1 cycle while '7' is still held -> key=10 next cycle; '7' re-accepted with exactly one key_valid.
